// File: rtl/pheap_root_pkg.sv
// Shared types for the pipelined heap: opcodes, heap entry layout, value and capacity widths.
package pheapTypes;

  localparam int CAP_W = 16;

  typedef logic [31:0]      pValue;
  typedef logic [CAP_W-1:0] cap_t;

  typedef enum logic [1:0] {
    NOP = 2'd0,
    ENQ = 2'd1,
    DEQ = 2'd2,
    LEQ = 2'd3
  } opcode_t;

  typedef struct packed {
    logic  active;
    cap_t  capacity;
    pValue priorityValue;
  } entry_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EXEC = 2'd2,
    HOLD = 2'd3
  } state_t;

endpackage

// File: rtl/pheap_root_if.sv
// Host request/response and level-2 handshake bundle seen by the heap root.
interface pheap_root_if;
  import pheapTypes::*;

  logic    op_valid;
  logic    op_ready;
  opcode_t op;
  pValue   op_data;
  logic    deq_valid;
  pValue   deq_data;
  logic    deq_empty;
  logic    enq_full;
  logic    empty;
  logic    full;
  logic    rd_en;
  entry_t  rBotL;
  entry_t  rBotR;
  logic    start;
  logic    startPos;
  opcode_t op_out;
  pValue   in;

  // Host plus level-2 memory side
  modport master (
    output op_valid, op, op_data, rBotL, rBotR,
    input  op_ready, deq_valid, deq_data, deq_empty, enq_full, empty, full,
           rd_en, start, startPos, op_out, in
  );

  // Heap root side
  modport slave (
    input  op_valid, op, op_data, rBotL, rBotR,
    output op_ready, deq_valid, deq_data, deq_empty, enq_full, empty, full,
           rd_en, start, startPos, op_out, in
  );

endinterface

// File: rtl/pheap_root.sv
// Root level of a pipelined max-heap: holds the root entry, serves ENQ/DEQ one per
// four cycles and pushes the displaced value or refill request down to level 2.
module pheap_root
  import pheapTypes::*;
#(
  parameter int LEVELS = 4
) (
  input logic         clk,
  input logic         rst,
  pheap_root_if.slave bus
);

  localparam cap_t CAP_MAX = cap_t'((1 << LEVELS) - 1);

  function automatic cap_t cap_dec(input cap_t c);
    return (c == '0) ? c : c - 1'b1;
  endfunction

  function automatic cap_t cap_inc(input cap_t c);
    return (c >= CAP_MAX) ? CAP_MAX : c + 1'b1;
  endfunction

  state_t  state, state_nx;
  entry_t  root_q, root_nx;
  opcode_t op_q;
  pValue   data_q;

  logic    op_ready_c, rd_en_c, start_c, start_pos_c;
  logic    deq_valid_c, deq_empty_c, enq_full_c;
  pValue   deq_data_c, in_c;
  opcode_t op_out_c;
  logic    pick_left;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      root_q <= '{active: 1'b0, capacity: CAP_MAX, priorityValue: '0};
      op_q   <= NOP;
      data_q <= '0;
    end else begin
      state  <= state_nx;
      root_q <= root_nx;
      if (bus.op_valid && op_ready_c) begin
        op_q   <= bus.op;
        data_q <= bus.op_data;
      end
    end
  end

  // Left child wins ties and is the only candidate when the right one is empty
  assign pick_left = bus.rBotL.active &&
                     (!bus.rBotR.active ||
                      (bus.rBotL.priorityValue >= bus.rBotR.priorityValue));

  always_comb begin
    state_nx    = state;
    root_nx     = root_q;
    op_ready_c  = 1'b0;
    rd_en_c     = 1'b0;
    start_c     = 1'b0;
    start_pos_c = 1'b0;
    deq_valid_c = 1'b0;
    deq_empty_c = 1'b0;
    enq_full_c  = 1'b0;
    deq_data_c  = '0;
    in_c        = '0;
    op_out_c    = LEQ;

    unique case (state)
      IDLE: begin
        op_ready_c = rst;
        if (bus.op_valid && rst) state_nx = READ;
      end
      READ: begin
        rd_en_c  = 1'b1;
        state_nx = EXEC;
      end
      EXEC: begin
        state_nx = HOLD;
        unique case (op_q)
          ENQ: begin
            if (root_q.capacity == '0) begin
              enq_full_c = 1'b1;
            end else if (!root_q.active) begin
              root_nx.active        = 1'b1;
              root_nx.capacity      = cap_dec(root_q.capacity);
              root_nx.priorityValue = data_q;
            end else begin
              root_nx.capacity = cap_dec(root_q.capacity);
              if (data_q > root_q.priorityValue) begin
                root_nx.priorityValue = data_q;
                in_c                  = root_q.priorityValue;
              end else begin
                in_c = data_q;
              end
              start_c     = 1'b1;
              op_out_c    = LEQ;
              start_pos_c = (bus.rBotL.capacity != '0) ? 1'b0 : 1'b1;
            end
          end
          DEQ: begin
            deq_valid_c = 1'b1;
            if (!root_q.active) begin
              deq_empty_c = 1'b1;
            end else begin
              deq_data_c       = root_q.priorityValue;
              root_nx.capacity = cap_inc(root_q.capacity);
              if (!bus.rBotL.active && !bus.rBotR.active) begin
                root_nx.active        = 1'b0;
                root_nx.priorityValue = '0;
              end else begin
                root_nx.priorityValue = pick_left ? bus.rBotL.priorityValue
                                                  : bus.rBotR.priorityValue;
                start_c     = 1'b1;
                op_out_c    = DEQ;
                start_pos_c = ~pick_left;
              end
            end
          end
          default: ;
        endcase
      end
      HOLD: begin
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  logic unused_bits;
  assign unused_bits = ^bus.rBotR.capacity;

  assign bus.op_ready  = op_ready_c;
  assign bus.rd_en     = rd_en_c;
  assign bus.start     = start_c;
  assign bus.startPos  = start_pos_c;
  assign bus.op_out    = op_out_c;
  assign bus.in        = in_c;
  assign bus.deq_valid = deq_valid_c;
  assign bus.deq_data  = deq_data_c;
  assign bus.deq_empty = deq_empty_c;
  assign bus.enq_full  = enq_full_c;
  assign bus.empty     = ~root_q.active;
  assign bus.full      = (root_q.capacity == '0);

endmodule
